// File: rtl/odd_parity_pkg.sv
//==============================================================================
// Module   : odd_parity_pkg
// Purpose  : Shared definitions for the odd-parity serial link (transmitter and
//            receiver/checker): frame state encoding, frame length and the
//            framing bit levels.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package odd_parity_pkg;

  // Default payload width of a frame.
  localparam int DATA_W_DFLT = 4;

  // start + data + parity + stop
  localparam int FRAME_BITS = DATA_W_DFLT + 3;

  // Line levels for the framing bits; the line idles at the stop level.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/odd_parity_bit_gen.sv
//==============================================================================
// Module   : odd_parity_bit_gen
// Purpose  : Combinational odd-parity generator. o_par is chosen so that
//            {i_data, o_par} holds an odd number of ones. The receiver reuses
//            this block to check incoming frames.
// Ports    : i_data [DATA_W-1:0] - data word
//            o_par                - odd parity bit for i_data
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module odd_parity_bit_gen #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] i_data,
  output logic              o_par
);

  assign o_par = ~^i_data;

endmodule

`default_nettype wire

// File: rtl/odd_parity_serial_tx.sv
//==============================================================================
// Module   : odd_parity_serial_tx
// Purpose  : Accepts a DATA_W-bit word over valid/ready, appends an odd parity
//            bit and shifts the frame out LSB first:
//            start(0), data[0..DATA_W-1], parity, stop(1); each bit is held
//            for CLKS_PER_BIT clocks.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            tx_valid - source presents a word on tx_data
//            tx_data  - word to send, sampled on handshake only
//            tx_ready - word can be accepted (IDLE, not in reset)
//            tx_out   - serial line, idles high
//            tx_par   - parity of the word in flight (registered)
//            busy     - frame in progress
//            done     - one-cycle pulse on the last cycle of the stop bit
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module odd_parity_serial_tx
  import odd_parity_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DFLT,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_par,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] c_LAST_TICK = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] c_LAST_BIT  = 3'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_tick;
  logic [2:0]        r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_ready;

  logic              w_accept;
  logic              w_bit_end;
  logic              w_par;
  logic              w_tx_out;
  logic              w_done;

  odd_parity_bit_gen #(
    .DATA_W (DATA_W)
  ) u_par_gen (
    .i_data (tx_data),
    .o_par  (w_par)
  );

  // r_ready is only ever set while the FSM is heading into IDLE, so it alone
  // qualifies the handshake.
  assign w_accept  = r_ready && tx_valid;
  assign w_bit_end = (r_tick == c_LAST_TICK);

  //--------------------------------------------------------------------------
  // Next state and line/strobe decode
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_tx_out    = STOP_BIT;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = START;
      end
      START: begin
        w_tx_out = START_BIT;
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        w_tx_out = r_shift[0];
        if (w_bit_end && (r_bit == c_LAST_BIT)) w_state_nxt = PARITY;
      end
      PARITY: begin
        w_tx_out = r_par;
        if (w_bit_end) w_state_nxt = STOP;
      end
      STOP: begin
        w_tx_out = STOP_BIT;
        if (w_bit_end) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  //--------------------------------------------------------------------------
  // Datapath: bit timer, bit index, shift register, parity, ready
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick  <= 8'd0;
      r_bit   <= 3'd0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      // Ready is registered so it stays low through reset and rises on the
      // first clock after release, and drops the cycle after a handshake.
      r_ready <= (w_state_nxt == IDLE);

      if (r_state == IDLE) begin
        r_tick <= 8'd0;
        if (w_accept) begin
          r_shift <= tx_data;
          r_par   <= w_par;
        end
      end else if (w_bit_end) begin
        r_tick <= 8'd0;
      end else begin
        r_tick <= r_tick + 8'd1;
      end

      // Index is cleared throughout START so it is zero on entering DATA.
      if (r_state == START) begin
        r_bit <= 3'd0;
      end else if ((r_state == DATA) && w_bit_end) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  assign tx_ready = r_ready;
  assign tx_out   = w_tx_out;
  assign tx_par   = r_par;
  assign busy     = (r_state != IDLE);
  assign done     = w_done;

endmodule

`default_nettype wire

// File: doc/odd_parity_serial_tx.md
# odd_parity_serial_tx

Transmit-side counterpart of the odd-parity nibble checker. Accepts a 4-bit data word over a valid/ready handshake, appends an odd parity bit, and shifts the framed word out serially, LSB first, with a fixed number of clocks per bit. The far end deserialises the frame and presents data plus parity to the odd-parity checker, whose error flag stays low for every frame this block sends.

## Interface
- DATA_W, 4: data bits per frame.
- CLKS_PER_BIT, 4: clock cycles each serial bit is held; legal range 1..255.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_valid  in  1  source has a word on tx_data.
- tx_data  in  DATA_W  word to send; sampled only on handshake.
- tx_ready  out  1  block can accept a word (high only in IDLE).
- tx_out  out  1  serial line; idles high.
- tx_par  out  1  parity bit of the word currently in flight (registered).
- busy  out  1  frame in progress (state != IDLE).
- done  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- Frame order: start (0), data[0]..data[DATA_W-1], parity, stop (1). Total DATA_W+3 bits.
- Parity: tx_par = ~^tx_data, so data plus parity always holds an odd count of ones. Example: 4'b0000 -> 1; 4'b1011 -> 0.
- FSM states and transitions:
  - IDLE: tx_out=1. On tx_valid && tx_ready, latch data into the shift register, latch tx_par, and go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_out = shift[0]. Shift right every CLKS_PER_BIT cycles. After DATA_W bits, go to PARITY.
  - PARITY: tx_out = tx_par for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. done=1 in the final cycle, then go to IDLE.
- Counters:
  - Bit-time counter is 8 bits. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit index counter is 3 bits, 0..DATA_W-1. It is cleared on entering DATA.
- Inputs are ignored outside IDLE. tx_data changing mid-frame has no effect.
- tx_valid held high continuously: a new word is accepted on the first IDLE cycle after each frame.
- Reset values (also forced asynchronously whenever rst_n=0):
  - state IDLE, tx_out=1, tx_par=0, busy=0, done=0.
  - tx_ready=0 while rst_n=0; it reads 1 from the first clock after release.
  - Counters and shift register cleared.
- Reset mid-frame: the frame is abandoned and tx_out returns to 1 immediately (asynchronous). No done pulse is produced.

## Timing
- Handshake at cycle T. tx_out drives the start bit from cycle T+1. busy rises at T+1.
- Each bit holds for exactly CLKS_PER_BIT cycles. The frame occupies cycles T+1 .. T+(DATA_W+3)*CLKS_PER_BIT (28 cycles at defaults).
- done is high on cycle T+(DATA_W+3)*CLKS_PER_BIT. IDLE and tx_ready=1 follow on the next cycle.
- Minimum spacing between handshakes is (DATA_W+3)*CLKS_PER_BIT+1 cycles. The line therefore has at least one idle-high cycle after the stop bit.
- CLKS_PER_BIT=1 is legal: one cycle per bit, same state sequence.

## Structure
- Shared package odd_parity_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - FRAME_BITS = DATA_W+3;
  - the start and stop bit constants.
  The receiver side uses the same package.
- One sub-module, odd_parity_bit_gen: combinational DATA_W-bit odd parity generator, reused by the receiver for checking.

## Test plan
- Reset, then send 4'b0000: tx_par=1. Line sequence, each bit held 4 cycles: 0,0,0,0,0,1,1. done on cycle 28 after handshake.
- Send 4'b1011: tx_par=0. Line sequence: 0,1,1,0,1,0,1.
- tx_valid held high with words 4'h5 then 4'hA: second handshake exactly 29 cycles after the first. Parity 1 for both. tx_out=1 for the one gap cycle.
- Toggle tx_data and tx_valid during DATA of a 4'h3 frame: transmitted bits remain 1,1,0,0 with parity 1. tx_ready stays 0.
- Assert rst_n=0 during PARITY: tx_out=1, busy=0 and done=0 without waiting for a clock. The next frame after release is correct.
- Loopback into the odd-parity checker over all 16 words: checker error flag stays 0 for every received frame.
